// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_bank register file.
package regfile_pkg;

    typedef enum logic {
        CLR_IDLE,
        CLR_ACTIVE
    } clr_state_e;

    localparam int DEF_DATA_W   = 4;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_NUM_RD   = 2;
    localparam int MAX_ADDR_BUS = 64;

    // Extracts read port 'port' from a packed address bus of addrW-bit fields.
    function automatic logic [MAX_ADDR_BUS-1:0] portAddr(
        input logic [MAX_ADDR_BUS-1:0] bus,
        input int                      port,
        input int                      addrW
    );
        logic [MAX_ADDR_BUS-1:0] mask;
        mask = (MAX_ADDR_BUS'(1) << addrW) - MAX_ADDR_BUS'(1);
        return (bus >> (port * addrW)) & mask;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reservations,
// cleared by writebacks, flushed wholesale when a bulk clear starts.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(DEF_NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_set_en,
    input  logic [ADDR_W-1:0]   i_set_addr,
    input  logic                i_clr_en,
    input  logic [ADDR_W-1:0]   i_clr_addr,
    input  logic                i_flush,
    output logic [NUM_REGS-1:0] o_pending
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pendingNext;

    // Set is applied after clear so a same-cycle reservation leaves the bit set.
    always_comb begin
        w_pendingNext = r_pending;
        if (i_flush) begin
            w_pendingNext = '0;
        end else begin
            if (i_clr_en) w_pendingNext[i_clr_addr] = 1'b0;
            if (i_set_en) w_pendingNext[i_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= w_pendingNext;
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/regfile_bank.sv
// Parametrised register file with pending-write scoreboard and bulk clear.
// Define REGFILE_BYPASS_EN for same-cycle writeback-to-read forwarding.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int NUM_RD   = DEF_NUM_RD,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_pending,
    input  logic                     i_rsv_en,
    input  logic [ADDR_W-1:0]        i_rsv_addr,
    input  logic                     i_clr_req,
    output logic                     o_clr_busy
);

    clr_state_e          r_state;
    clr_state_e          w_stateNext;
    logic [ADDR_W-1:0]   r_clrIdx;
    logic [ADDR_W-1:0]   w_clrIdxNext;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_pending;
    logic                w_idle;
    logic                w_flush;
    logic                w_wrAccept;
    logic                w_rsvAccept;

    // Traffic on the edge that enters CLEAR is dropped along with everything during CLEAR.
    assign w_idle      = (r_state == CLR_IDLE);
    assign w_flush     = w_idle && i_clr_req;
    assign w_wrAccept  = w_idle && !i_clr_req && i_wr_en
                         && !((ZERO_REG != 0) && (i_wr_addr == '0));
    assign w_rsvAccept = w_idle && !i_clr_req && i_rsv_en
                         && !((ZERO_REG != 0) && (i_rsv_addr == '0));
    assign o_clr_busy  = (r_state == CLR_ACTIVE);

    always_comb begin
        w_stateNext  = r_state;
        w_clrIdxNext = r_clrIdx;
        case (r_state)
            CLR_IDLE: begin
                if (i_clr_req) begin
                    w_stateNext  = CLR_ACTIVE;
                    w_clrIdxNext = '0;
                end
            end
            CLR_ACTIVE: begin
                w_clrIdxNext = r_clrIdx + ADDR_W'(1);
                if (r_clrIdx == ADDR_W'(NUM_REGS - 1)) w_stateNext = CLR_IDLE;
            end
            default: w_stateNext = CLR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= CLR_IDLE;
            r_clrIdx <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_clrIdx <= w_clrIdxNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (r_state == CLR_ACTIVE) begin
            r_regs[r_clrIdx] <= '0;
        end else if (w_wrAccept) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (w_rsvAccept),
        .i_set_addr (i_rsv_addr),
        .i_clr_en   (w_wrAccept),
        .i_clr_addr (i_wr_addr),
        .i_flush    (w_flush),
        .o_pending  (w_pending)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_pend;

        assign w_addr = ADDR_W'(portAddr(MAX_ADDR_BUS'(i_rd_addr), k, ADDR_W));

        // A forwarded write has retired its producer unless a new one is reserved now.
        always_comb begin
            w_data = r_regs[w_addr];
            w_pend = w_pending[w_addr];
`ifdef REGFILE_BYPASS_EN
            if (w_wrAccept && (i_wr_addr == w_addr)) begin
                w_data = i_wr_data;
                w_pend = w_rsvAccept && (i_rsv_addr == w_addr);
            end
`endif
            if ((ZERO_REG != 0) && (w_addr == '0)) begin
                w_data = '0;
                w_pend = 1'b0;
            end
        end

        assign o_rd_data[k*DATA_W +: DATA_W] = w_data;
        assign o_rd_pending[k]               = w_pend;
    end

endmodule

// File: tb/tb_regfile_bank.sv
// Directed self-checking bench for regfile_bank: default instance plus a
// wide/deep instance without a hardwired zero register.
module tb_regfile_bank;

    logic clk = 1'b0;
    logic rst_n;

    logic        wrEn;
    logic [3:0]  wrAddr;
    logic [3:0]  wrData;
    logic [7:0]  rdAddr;
    logic [7:0]  rdData;
    logic [1:0]  rdPending;
    logic        rsvEn;
    logic [3:0]  rsvAddr;
    logic        clrReq;
    logic        clrBusy;

    logic        wrEnB;
    logic [4:0]  wrAddrB;
    logic [7:0]  wrDataB;
    logic [14:0] rdAddrB;
    logic [23:0] rdDataB;
    logic [2:0]  rdPendingB;
    logic        rsvEnB;
    logic [4:0]  rsvAddrB;
    logic        clrReqB;
    logic        clrBusyB;

    int errors = 0;
    int checks = 0;
    int busyCount;
    logic [3:0] bypassExp;

    always #5 clk = ~clk;

    regfile_bank #(
        .DATA_W   (4),
        .NUM_REGS (16),
        .NUM_RD   (2),
        .ZERO_REG (1)
    ) dutA (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (wrEn),
        .i_wr_addr    (wrAddr),
        .i_wr_data    (wrData),
        .i_rd_addr    (rdAddr),
        .o_rd_data    (rdData),
        .o_rd_pending (rdPending),
        .i_rsv_en     (rsvEn),
        .i_rsv_addr   (rsvAddr),
        .i_clr_req    (clrReq),
        .o_clr_busy   (clrBusy)
    );

    regfile_bank #(
        .DATA_W   (8),
        .NUM_REGS (32),
        .NUM_RD   (3),
        .ZERO_REG (0)
    ) dutB (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (wrEnB),
        .i_wr_addr    (wrAddrB),
        .i_wr_data    (wrDataB),
        .i_rd_addr    (rdAddrB),
        .o_rd_data    (rdDataB),
        .o_rd_pending (rdPendingB),
        .i_rsv_en     (rsvEnB),
        .i_rsv_addr   (rsvAddrB),
        .i_clr_req    (clrReqB),
        .o_clr_busy   (clrBusyB)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [3:0] wd,
                                 input logic re, input logic [3:0] ra, input logic cr);
        wrEn    = we;
        wrAddr  = wa;
        wrData  = wd;
        rsvEn   = re;
        rsvAddr = ra;
        clrReq  = cr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        rdAddr  = 8'h33;
        wrEnB   = 1'b0;
        wrAddrB = '0;
        wrDataB = '0;
        rdAddrB = '0;
        rsvEnB  = 1'b0;
        rsvAddrB = '0;
        clrReqB = 1'b0;
        tick();
        tick();
        checkOutput("resetClrBusy", 32'(clrBusy), 32'h0);
        checkOutput("resetReadData", 32'(rdData), 32'h0);
        checkOutput("resetPending", 32'(rdPending), 32'h0);
        checkOutput("resetClrBusyB", 32'(clrBusyB), 32'h0);
        rst_n = 1'b1;

        applyStimulus(1'b1, 4'h3, 4'h5, 1'b0, 4'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        #1;
        checkOutput("r3Port0", 32'(rdData[3:0]), 32'h5);
        checkOutput("r3Port1", 32'(rdData[7:4]), 32'h5);

        applyStimulus(1'b1, 4'h0, 4'hF, 1'b0, 4'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        rdAddr = 8'h00;
        #1;
        checkOutput("r0ReadsZero", 32'(rdData[3:0]), 32'h0);

        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'h7, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        rdAddr = 8'h77;
        #1;
        checkOutput("rsvPendingR7", 32'(rdPending), 32'h3);
        tick();
        applyStimulus(1'b1, 4'h7, 4'hA, 1'b0, 4'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        #1;
        checkOutput("writeClearsPending", 32'(rdPending), 32'h0);
        checkOutput("r7DataA", 32'(rdData[3:0]), 32'hA);

        applyStimulus(1'b1, 4'h7, 4'h6, 1'b1, 4'h7, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        #1;
        checkOutput("rsvWinsPending", 32'(rdPending[0]), 32'h1);
        checkOutput("rsvWinsData", 32'(rdData[3:0]), 32'h6);

        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 4'(i), 1'b0, 4'h0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'h9, 1'b0);
        tick();

        // Reservation of r10 rides on the clear-entry edge and must be dropped.
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'hA, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        rdAddr = {4'hC, 4'h5};
        busyCount = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (clrBusy !== 1'b1) break;
            busyCount++;
            if (n == 5) checkOutput("r5BeforeClear", 32'(rdData[3:0]), 32'h5);
            if (n == 6) begin
                checkOutput("r5AfterClear", 32'(rdData[3:0]), 32'h0);
                checkOutput("r12Retained", 32'(rdData[7:4]), 32'hC);
            end
            if (n == 12) checkOutput("r12BeforeClear", 32'(rdData[7:4]), 32'hC);
            if (n == 13) checkOutput("r12AfterClear", 32'(rdData[7:4]), 32'h0);
            applyStimulus((n == 4), 4'h2, 4'h9, 1'b0, 4'h0, 1'b0);
            tick();
        end
        checkOutput("clrBusyCycles", 32'(busyCount), 32'd16);
        rdAddr = {4'hF, 4'h2};
        #1;
        checkOutput("writeDuringClearLost", 32'(rdData[3:0]), 32'h0);
        checkOutput("r15Cleared", 32'(rdData[7:4]), 32'h0);
        rdAddr = {4'hA, 4'h9};
        #1;
        checkOutput("clearFlushedPending", 32'(rdPending), 32'h0);

        applyStimulus(1'b1, 4'hC, 4'hC, 1'b0, 4'h0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'hD, 4'hD, 1'b0, 4'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        repeat (8) tick();
        rdAddr = {4'hD, 4'hC};
        #1;
        checkOutput("midClearBusy", 32'(clrBusy), 32'h1);
        checkOutput("midClearOldData", 32'(rdData), 32'hDC);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetBusy", 32'(clrBusy), 32'h0);
        checkOutput("asyncResetData", 32'(rdData), 32'h0);
        checkOutput("asyncResetPending", 32'(rdPending), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("postResetIdle", 32'(clrBusy), 32'h0);
        checkOutput("postResetData", 32'(rdData), 32'h0);

`ifdef REGFILE_BYPASS_EN
        bypassExp = 4'hC;
`else
        bypassExp = 4'h3;
`endif
        applyStimulus(1'b1, 4'h4, 4'h3, 1'b0, 4'h0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'h4, 4'hC, 1'b0, 4'h0, 1'b0);
        rdAddr = 8'h44;
        #1;
        checkOutput("bypassSameCycle", 32'(rdData[3:0]), 32'(bypassExp));
        tick();
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        #1;
        checkOutput("writeNextCycle", 32'(rdData[7:4]), 32'hC);

        wrEnB   = 1'b1;
        wrAddrB = 5'd0;
        wrDataB = 8'h7E;
        rdAddrB = {5'd0, 5'd31, 5'd0};
        tick();
        wrAddrB = 5'd31;
        wrDataB = 8'h55;
        tick();
        wrEnB = 1'b0;
        #1;
        checkOutput("bR0Writable", 32'(rdDataB[7:0]), 32'h7E);
        checkOutput("bR31Port1", 32'(rdDataB[15:8]), 32'h55);
        checkOutput("bR0Port2", 32'(rdDataB[23:16]), 32'h7E);
        clrReqB = 1'b1;
        tick();
        clrReqB = 1'b0;
        busyCount = 0;
        for (int n = 0; n < 80; n++) begin
            #1;
            if (clrBusyB !== 1'b1) break;
            busyCount++;
            tick();
        end
        checkOutput("bClrBusyCycles", 32'(busyCount), 32'd32);
        checkOutput("bR0Cleared", 32'(rdDataB[7:0]), 32'h0);
        checkOutput("bR31Cleared", 32'(rdDataB[15:8]), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
Parametrised successor to the 16x4 processor register file. It provides:
- configurable width, depth and read-port count;
- optional hardwired-zero r0;
- a per-register pending-write scoreboard for hazard detection;
- a sequenced bulk-clear engine.

It sits between decode (reads, reservations) and writeback (writes) in the RISC-4 core.

Parameters:
DATA_W, 4, register width in bits
NUM_REGS, 16, number of registers (power of two, >=2)
NUM_RD, 2, number of asynchronous read ports (1..4)
ZERO_REG, 1, 1 = r0 reads 0 and is never written, reserved or pending
ADDR_W, $clog2(NUM_REGS), derived localparam; not overridable

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback register index
wr_data  in  DATA_W  writeback data
rd_addr  in  NUM_RD*ADDR_W  packed read indices, port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
rd_pending  out  NUM_RD  pending bit of the register addressed by each port
rsv_en  in  1  decode reserves a destination (marks it pending)
rsv_addr  in  ADDR_W  register to reserve
clr_req  in  1  start bulk clear
clr_busy  out  1  bulk clear in progress

Behaviour:
- Reset (async assert):
  - all registers 0; all pending bits 0;
  - FSM = IDLE; clr_busy = 0; clear index = 0.
- Write:
  - registers[wr_addr] <= wr_data on the rising edge when wr_en=1 and FSM=IDLE.
  - Ignored when ZERO_REG=1 and wr_addr=0.
  - A write clears pending[wr_addr] on the same edge.
- Read:
  - rd_data[k] = registers[rd_addr[k]], combinational, zero-latency.
  - Forced to 0 when ZERO_REG=1 and rd_addr[k]=0.
- Scoreboard:
  - rsv_en=1 in IDLE sets pending[rsv_addr] on the next edge.
  - rsv_addr=0 with ZERO_REG=1 is ignored.
  - rsv_en and wr_en to the same address in the same cycle: the reservation wins and the bit ends set, because a new producer was issued. The data is still written.
  - rd_pending[k] = pending[rd_addr[k]], combinational.
- FSM, IDLE -> CLEAR:
  - Taken on clr_req=1. Pending bits are all cleared on that edge; the index is loaded with 0.
  - Any wr_en/rsv_en sampled on that transition edge is dropped.
- FSM, CLEAR:
  - clr_busy=1 (registered; asserts the cycle after clr_req).
  - Each edge, registers[index] <= 0 and index increments.
  - After the edge clearing index NUM_REGS-1: FSM -> IDLE, clr_busy -> 0. Total busy = NUM_REGS cycles.
  - wr_en, rsv_en and clr_req are ignored (dropped, not queued).
  - Reads stay functional: cleared entries read 0, uncleared entries read old data.
- Async reset mid-clear: immediate return to IDLE with everything zeroed.
- Index arithmetic: ADDR_W bits; wrap after NUM_REGS-1 is unreachable because the FSM exits first.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: rd_data[k] returns wr_data combinationally when a write is accepted this cycle (wr_en, IDLE, not the zero reg) and wr_addr==rd_addr[k]. rd_pending[k] reads 0 in that case unless rsv_en targets the same address. This gives same-cycle writeback-to-decode forwarding.
- Undefined: reads always return stored contents; the new value is visible the cycle after the write edge.

Decomposition:
- Package regfile_pkg holds:
  - state enum clr_state_e {CLR_IDLE, CLR_ACTIVE};
  - default width/depth constants;
  - a function unpacking a port slice from the packed address bus.
- Sub-module regfile_scoreboard (NUM_REGS, ADDR_W) holds the pending-bit vector plus its set/clear/flush logic.
- Storage, read muxing, bypass and the clear FSM stay in regfile_bank.

Test Plan:
- Reset, then write 0x5 to r3, read r3 on ports 0 and 1 -> both 0x5 next cycle; write 0xF to r0 -> r0 reads 0x0.
- rsv_en r7 -> rd_pending=1 for r7; wr_en r7 data 0xA two cycles later -> pending 0, read 0xA; same-cycle rsv+wr to r7 -> pending 1, data written.
- Fill r1..r15 with nonzero values, pulse clr_req -> clr_busy high exactly 16 cycles:
  - r5 reads 0 once index passes 5; r12 retains its old value until then;
  - a write of 0x9 to r2 during clear is lost (reads 0 after).
- Assert rst_n low at clear index 8 -> clr_busy 0 immediately; all registers and pending bits 0.
- With REGFILE_BYPASS_EN: wr_en r4 0xC while rd_addr=4 -> rd_data 0xC same cycle. Without it: old value this cycle, 0xC next.
- Parameter sweep DATA_W=8, NUM_REGS=32, NUM_RD=3, ZERO_REG=0 -> r0 writable (0x7E readback); clear lasts 32 cycles.
